// File: rtl/ysyx_22040000_lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states
// and the per-size byte mask used by the lane alignment logic.
package ysyx_22040000_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  localparam logic [1:0] SZ_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_e;

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 4'h1;
      SZ_H:    return 4'h3;
      SZ_W:    return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22040000_lsu_align.sv
// Combinational lane alignment: positions store data/mask across two words and
// extracts plus extends load data from the two captured read words.
module ysyx_22040000_lsu_align
  import ysyx_22040000_lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [63:0] rbuf,
  output logic [7:0]  mask8,
  output logic [63:0] data64,
  output logic [31:0] rdata
);

  logic [5:0]  sh;
  logic [31:0] raw;

  function automatic logic [31:0] extend(input logic [31:0] r, input logic [1:0] sz,
                                         input logic u);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = r[7:0];
    h = r[15:0];
    case (sz)
      SZ_B:    return u ? {24'b0, r[7:0]}  : 32'(b);
      SZ_H:    return u ? {16'b0, r[15:0]} : 32'(h);
      SZ_W:    return r;
      default: return 32'b0;
    endcase
  endfunction

  assign sh     = {off, 3'b000};
  assign mask8  = {4'b0000, size_mask(size)} << off;
  assign data64 = {32'b0, wdata} << sh;
  // Only the low word survives: bytes beyond the access size are dropped by extend().
  assign raw    = 32'(rbuf >> sh);
  assign rdata  = extend(raw, size, uns);

endmodule

// File: rtl/ysyx_22040000_lsu.sv
// Load/store unit in front of a word-organised memory with async read and
// byte-enable sync write; splits word-crossing accesses into two beats.
module ysyx_22040000_lsu
  import ysyx_22040000_lsu_pkg::*;
#(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [AWIDTH+1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DWIDTH-1:0] resp_rdata,
  output logic              resp_err,
  output logic [AWIDTH-1:0] mem_raddr,
  output logic [AWIDTH-1:0] mem_waddr,
  output logic [3:0]        mem_wbe,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);

  generate
    if (DWIDTH != 32) begin : g_bad_dwidth
      $error("ysyx_22040000_lsu supports DWIDTH == 32 only");
    end
  endgenerate

  state_e              state, state_nxt;
  logic                accept;
  logic                we_q, uns_q;
  logic [1:0]          size_q;
  logic [AWIDTH+1:0]   addr_q;
  logic [31:0]         wdata_q, buf0, buf1;
  logic [AWIDTH-1:0]   w0, w1;
  logic [7:0]          mask8;
  logic [63:0]         data64;
  logic [31:0]         ld_data;
  logic                split;

  assign accept = req_valid & req_ready;
  assign w0     = addr_q[AWIDTH+1:2];
  assign w1     = w0 + AWIDTH'(1);
  assign split  = |mask8[7:4];

  ysyx_22040000_lsu_align u_align (
    .off   (addr_q[1:0]),
    .size  (size_q),
    .uns   (uns_q),
    .wdata (wdata_q),
    .rbuf  ({buf1, buf0}),
    .mask8 (mask8),
    .data64(data64),
    .rdata (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Request latch and read buffers carry data only; the FSM qualifies their use.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
    if (state == BEAT0 && !we_q) buf0 <= mem_rdata;
    if (state == BEAT1 && !we_q) buf1 <= mem_rdata;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_raddr  = '0;
    mem_waddr  = '0;
    mem_wbe    = 4'b0000;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = (req_size == SZ_ILLEGAL) ? RESP : BEAT0;
      end
      BEAT0: begin
        mem_raddr = w0;
        mem_waddr = w0;
        if (we_q) begin
          mem_wbe   = mask8[3:0];
          mem_wdata = data64[31:0];
        end
        state_nxt = split ? BEAT1 : RESP;
      end
      BEAT1: begin
        mem_raddr = w1;
        mem_waddr = w1;
        if (we_q) begin
          mem_wbe   = mask8[7:4];
          mem_wdata = data64[63:32];
        end
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign resp_err   = (state == RESP) && (size_q == SZ_ILLEGAL);
  assign resp_rdata = ((state == RESP) && !we_q && !resp_err) ? ld_data : '0;

endmodule

// File: tb/tb_ysyx_22040000_lsu.sv
// Directed bench for the load/store unit, with a zero-initialised word memory
// model (async read, byte-enable sync write) attached to the MEM port.
module tb_ysyx_22040000_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [11:0] req_addr = 12'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  mem_raddr, mem_waddr;
  logic [3:0]  mem_wbe;
  logic [31:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  ysyx_22040000_lsu #(.AWIDTH(10), .DWIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wbe(mem_wbe),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  bit          mem_inited;
  assign mem_rdata = mem[mem_raddr];

  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem_inited <= 1'b1;
    end else begin
      for (int i = 0; i < 4; i++)
        if (mem_wbe[i]) mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  // Per-cycle observations after an accept; index n = cycles after the accept edge.
  logic [3:0]  ob_wbe   [1:8];
  logic [9:0]  ob_waddr [1:8];
  logic [9:0]  ob_raddr [1:8];
  logic [31:0] ob_wdata [1:8];
  int          lat;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        any_wbe;
  logic        ready_at_send;

  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [11:0] addr, input logic [31:0] wd);
    @(negedge clk);
    ready_at_send = req_ready;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic collect();
    lat = -1; any_wbe = 1'b0; r_rdata = 32'hx; r_err = 1'bx;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      ob_wbe[n] = mem_wbe; ob_waddr[n] = mem_waddr;
      ob_raddr[n] = mem_raddr; ob_wdata[n] = mem_wdata;
      if (mem_wbe != 4'b0) any_wbe = 1'b1;
      if (resp_valid) begin
        lat = n; r_rdata = resp_rdata; r_err = resp_err;
        break;
      end
    end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [11:0] addr, input logic [31:0] wd);
    send(we, size, uns, addr, wd);
    collect();
    finish_resp();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", resp_err); end
    checks++; if (mem_wbe !== 4'b0) begin errors++; $display("FAIL reset_wbe got %b want 0000", mem_wbe); end
    checks++; if ({mem_raddr, mem_waddr} !== 20'h0) begin errors++; $display("FAIL reset_addr got %h/%h want 0/0", mem_raddr, mem_waddr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", mem_wdata); end
    rst_n = 1'b1;
  endtask

  task automatic test_word();
    access(1'b1, 2'd2, 1'b0, 12'h004, 32'h12345678);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency got %0d want 2", lat); end
    checks++; if (ob_waddr[1] !== 10'h1) begin errors++; $display("FAIL sw_waddr got %h want 001", ob_waddr[1]); end
    checks++; if (ob_wbe[1] !== 4'b1111) begin errors++; $display("FAIL sw_wbe got %b want 1111", ob_wbe[1]); end
    checks++; if (ob_wdata[1] !== 32'h12345678) begin errors++; $display("FAIL sw_wdata got %h want 12345678", ob_wdata[1]); end
    checks++; if (r_rdata !== 32'h0 || r_err !== 1'b0) begin errors++; $display("FAIL sw_resp got %h/%b want 0/0", r_rdata, r_err); end
    checks++; if (mem[1] !== 32'h12345678) begin errors++; $display("FAIL sw_mem1 got %h want 12345678", mem[1]); end
    access(1'b0, 2'd2, 1'b0, 12'h004, 32'h0);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency got %0d want 2", lat); end
    checks++; if (r_rdata !== 32'h12345678) begin errors++; $display("FAIL lw_rdata got %h want 12345678", r_rdata); end
    checks++; if (ob_raddr[1] !== 10'h1) begin errors++; $display("FAIL lw_raddr got %h want 001", ob_raddr[1]); end
    checks++; if (any_wbe !== 1'b0) begin errors++; $display("FAIL lw_wbe got %b want 0", any_wbe); end
  endtask

  task automatic test_byte();
    access(1'b1, 2'd0, 1'b0, 12'h006, 32'h000000AB);
    checks++; if (ob_wbe[1] !== 4'b0100) begin errors++; $display("FAIL sb_wbe got %b want 0100", ob_wbe[1]); end
    checks++; if (ob_wdata[1] !== 32'h00AB0000) begin errors++; $display("FAIL sb_wdata got %h want 00AB0000", ob_wdata[1]); end
    checks++; if (mem[1] !== 32'h12AB5678) begin errors++; $display("FAIL sb_mem1 got %h want 12AB5678", mem[1]); end
    access(1'b0, 2'd0, 1'b0, 12'h006, 32'h0);
    checks++; if (r_rdata !== 32'hFFFFFFAB) begin errors++; $display("FAIL lb_rdata got %h want FFFFFFAB", r_rdata); end
    access(1'b0, 2'd0, 1'b1, 12'h006, 32'h0);
    checks++; if (r_rdata !== 32'h000000AB) begin errors++; $display("FAIL lbu_rdata got %h want 000000AB", r_rdata); end
  endtask

  task automatic test_split();
    access(1'b1, 2'd2, 1'b0, 12'h007, 32'hDEADBEEF);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sws_latency got %0d want 3", lat); end
    checks++; if ({ob_waddr[1], ob_wbe[1]} !== {10'h1, 4'b1000}) begin errors++; $display("FAIL sws_beat0 got %h/%b want 001/1000", ob_waddr[1], ob_wbe[1]); end
    checks++; if (ob_wdata[1] !== 32'hEF000000) begin errors++; $display("FAIL sws_wdata0 got %h want EF000000", ob_wdata[1]); end
    checks++; if ({ob_waddr[2], ob_wbe[2]} !== {10'h2, 4'b0111}) begin errors++; $display("FAIL sws_beat1 got %h/%b want 002/0111", ob_waddr[2], ob_wbe[2]); end
    checks++; if (ob_wdata[2] !== 32'h00DEADBE) begin errors++; $display("FAIL sws_wdata1 got %h want 00DEADBE", ob_wdata[2]); end
    access(1'b0, 2'd2, 1'b0, 12'h007, 32'h0);
    checks++; if (lat !== 3) begin errors++; $display("FAIL lws_latency got %0d want 3", lat); end
    checks++; if (r_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lws_rdata got %h want DEADBEEF", r_rdata); end
    checks++; if (ob_raddr[2] !== 10'h2) begin errors++; $display("FAIL lws_raddr1 got %h want 002", ob_raddr[2]); end
  endtask

  task automatic test_wrap();
    access(1'b1, 2'd1, 1'b0, 12'hFFF, 32'h0000CAFE);
    checks++; if ({ob_waddr[1], ob_wbe[1]} !== {10'h3FF, 4'b1000}) begin errors++; $display("FAIL shw_beat0 got %h/%b want 3FF/1000", ob_waddr[1], ob_wbe[1]); end
    checks++; if ({ob_waddr[2], ob_wbe[2]} !== {10'h000, 4'b0001}) begin errors++; $display("FAIL shw_beat1 got %h/%b want 000/0001", ob_waddr[2], ob_wbe[2]); end
    checks++; if ({ob_wdata[1], ob_wdata[2]} !== {32'hFE000000, 32'h000000CA}) begin errors++; $display("FAIL shw_wdata got %h/%h want FE000000/000000CA", ob_wdata[1], ob_wdata[2]); end
    access(1'b0, 2'd1, 1'b1, 12'hFFF, 32'h0);
    checks++; if (r_rdata !== 32'h0000CAFE) begin errors++; $display("FAIL lhu_wrap got %h want 0000CAFE", r_rdata); end
    access(1'b0, 2'd1, 1'b0, 12'hFFF, 32'h0);
    checks++; if (r_rdata !== 32'hFFFFCAFE) begin errors++; $display("FAIL lh_wrap got %h want FFFFCAFE", r_rdata); end
  endtask

  task automatic test_hold();
    resp_ready = 1'b0;
    send(1'b0, 2'd2, 1'b0, 12'h004, 32'h0);
    collect();
    checks++; if (lat !== 2 || r_rdata !== 32'hEFAB5678) begin errors++; $display("FAIL hold_first got lat %0d %h want 2 EFAB5678", lat, r_rdata); end
    // Offer a store while busy; it must not be taken.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 12'h020; req_wdata = 32'hBADBAD00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if ({resp_valid, req_ready} !== 2'b10) begin errors++; $display("FAIL hold_valid_ready got %b want 10", {resp_valid, req_ready}); end
      checks++; if (resp_rdata !== 32'hEFAB5678) begin errors++; $display("FAIL hold_rdata got %h want EFAB5678", resp_rdata); end
    end
    req_valid = 1'b0;
    finish_resp();
    @(negedge clk);
    checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL hold_release got %b want 01", {resp_valid, req_ready}); end
    checks++; if (mem[8] !== 32'h0) begin errors++; $display("FAIL hold_no_write got %h want 0", mem[8]); end
  endtask

  task automatic test_illegal();
    access(1'b1, 2'd3, 1'b0, 12'h010, 32'hFFFFFFFF);
    checks++; if (lat !== 1) begin errors++; $display("FAIL ill_st_latency got %0d want 1", lat); end
    checks++; if ({r_err, r_rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL ill_st_resp got %b/%h want 1/0", r_err, r_rdata); end
    checks++; if (any_wbe !== 1'b0 || mem[4] !== 32'h0) begin errors++; $display("FAIL ill_st_nowrite got %b/%h want 0/0", any_wbe, mem[4]); end
    access(1'b0, 2'd3, 1'b1, 12'h004, 32'h0);
    checks++; if (lat !== 1 || {r_err, r_rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL ill_ld_resp got %0d %b/%h want 1 1/0", lat, r_err, r_rdata); end
    access(1'b0, 2'd2, 1'b0, 12'h004, 32'h0);
    checks++; if ({r_err, r_rdata} !== {1'b0, 32'hEFAB5678}) begin errors++; $display("FAIL ill_after got %b/%h want 0/EFAB5678", r_err, r_rdata); end
  endtask

  task automatic test_back_to_back();
    access(1'b1, 2'd2, 1'b0, 12'h00C, 32'h55AA55AA);
    access(1'b0, 2'd2, 1'b0, 12'h00C, 32'h0);
    checks++; if (ready_at_send !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", ready_at_send); end
    checks++; if (lat !== 2 || r_rdata !== 32'h55AA55AA) begin errors++; $display("FAIL b2b_load got %0d %h want 2 55AA55AA", lat, r_rdata); end
  endtask

  task automatic test_reset_mid();
    send(1'b1, 2'd2, 1'b0, 12'h00E, 32'h11223344);
    @(negedge clk);
    checks++; if ({mem_waddr, mem_wbe} !== {10'h3, 4'b1100}) begin errors++; $display("FAIL rm_beat0 got %h/%b want 003/1100", mem_waddr, mem_wbe); end
    @(posedge clk);
    #1;
    checks++; if ({mem_waddr, mem_wbe} !== {10'h4, 4'b0011}) begin errors++; $display("FAIL rm_beat1 got %h/%b want 004/0011", mem_waddr, mem_wbe); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_wbe !== 4'b0) begin errors++; $display("FAIL rm_wbe_drop got %b want 0000", mem_wbe); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (mem[4] !== 32'h0) begin errors++; $display("FAIL rm_word4 got %h want 0", mem[4]); end
    checks++; if (mem[3] !== 32'h334455AA) begin errors++; $display("FAIL rm_word3 got %h want 334455AA", mem[3]); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({req_ready, resp_valid} !== 2'b10) begin errors++; $display("FAIL rm_after got %b want 10", {req_ready, resp_valid}); end
    access(1'b0, 2'd2, 1'b0, 12'h00E, 32'h0);
    checks++; if (lat !== 3 || r_rdata !== 32'h00003344) begin errors++; $display("FAIL rm_reload got %0d %h want 3 00003344", lat, r_rdata); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_split();
    test_wrap();
    test_hold();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
